multicycle_control_unit: RTL and testbench

//  Sequential control unit for the multicycle RV32I datapath; the producer side of the ALU control bus.

---
 rtl/riscv_ctrl_pkg.sv | 85 ++++++++
 rtl/multicycle_control_unit_alu_decoder.sv | 38 +++
 rtl/multicycle_control_unit.sv | 171 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit and its ALU decoder.
package riscv_ctrl_pkg;

    localparam int unsigned ALU_W    = 3;
    localparam int unsigned OP_W     = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned MUX_W    = 2;

    // Control FSM states, 4-bit codes
    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTER = 4'd7,
        S_EXECUTEI = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11
    } state_e;

    // ALU operation codes shared with the ALU
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    // Supported opcodes
    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    // Datapath mux selects
    localparam logic [MUX_W-1:0] RESULT_ALUOUT   = 2'b00;
    localparam logic [MUX_W-1:0] RESULT_READDATA = 2'b01;
    localparam logic [MUX_W-1:0] RESULT_ALU      = 2'b10;
    localparam logic [MUX_W-1:0] SRCA_PC         = 2'b00;
    localparam logic [MUX_W-1:0] SRCA_OLDPC      = 2'b01;
    localparam logic [MUX_W-1:0] SRCA_RS1        = 2'b10;
    localparam logic [MUX_W-1:0] SRCB_RS2        = 2'b00;
    localparam logic [MUX_W-1:0] SRCB_IMM        = 2'b01;
    localparam logic [MUX_W-1:0] SRCB_FOUR       = 2'b10;
    localparam logic [MUX_W-1:0] IMM_I           = 2'b00;
    localparam logic [MUX_W-1:0] IMM_S           = 2'b01;
    localparam logic [MUX_W-1:0] IMM_B           = 2'b10;
    localparam logic [MUX_W-1:0] IMM_J           = 2'b11;

    // ALU decoder request: fixed add, fixed subtract, or funct-field decode
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Per-state control word produced by the FSM decode
    typedef struct packed {
        logic             pc_update;
        logic             branch;
        logic             adr_src;
        logic             mem_write;
        logic             ir_write;
        logic             reg_write;
        logic [MUX_W-1:0] result_src;
        logic [MUX_W-1:0] alu_src_a;
        logic [MUX_W-1:0] alu_src_b;
        logic [1:0]       alu_op;
        logic             illegal;
    } ctrl_t;

    // Immediate format selected purely by opcode
    function automatic logic [MUX_W-1:0] imm_src_of(input logic [OP_W-1:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU decoder: maps the FSM request and funct fields onto the ALU operation code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0]          i_alu_op,
    input  logic [FUNCT3_W-1:0] i_funct3,
    input  logic                i_funct7b5,
    input  logic                i_op5,
    output logic [ALU_W-1:0]    o_alu_ctrl,
    output logic                o_bad_funct
);

    logic [ALU_W-1:0] w_funct_ctrl;

    // funct3 decode; only R-type (op5=1) can select subtract
    always_comb begin
        w_funct_ctrl = ALU_ADD;
        o_bad_funct  = 1'b0;
        case (i_funct3)
            3'b000:  w_funct_ctrl = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_funct_ctrl = ALU_SLT;
            3'b110:  w_funct_ctrl = ALU_OR;
            3'b111:  w_funct_ctrl = ALU_AND;
            default: o_bad_funct  = 1'b1;
        endcase
    end

    // Select between fixed operations and the funct decode
    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB:   o_alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: o_alu_ctrl = w_funct_ctrl;
            default:     o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: state sequencing and datapath control decode.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic                funct7b5,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic [MUX_W-1:0]    result_src,
    output logic [MUX_W-1:0]    alu_src_a,
    output logic [MUX_W-1:0]    alu_src_b,
    output logic [ALU_W-1:0]    alu_ctrl,
    output logic [MUX_W-1:0]    imm_src,
    output logic                illegal_instr
);

    state_e           r_state;
    state_e           w_next_state;
    ctrl_t            w_ctrl;
    logic [ALU_W-1:0] w_alu_ctrl;
    logic             w_bad_funct;
    logic             w_in_reset;

    alu_decoder u_alu_decoder (
        .i_alu_op   (w_ctrl.alu_op),
        .i_funct3   (funct3),
        .i_funct7b5 (funct7b5),
        .i_op5      (op[5]),
        .o_alu_ctrl (w_alu_ctrl),
        .o_bad_funct(w_bad_funct)
    );

    // State register; reset forces S_RESET so all state-decoded outputs drop at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        w_next_state = r_state;
        w_ctrl       = '0;
        w_ctrl.alu_op = ALUOP_ADD;
        case (r_state)
            S_RESET: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                w_ctrl.alu_src_a  = SRCA_PC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RESULT_ALU;
                w_ctrl.ir_write   = mem_ready;
                w_ctrl.pc_update  = mem_ready;
                if (mem_ready) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R: begin
                        w_ctrl.illegal = w_bad_funct;
                        w_next_state   = w_bad_funct ? S_FETCH : S_EXECUTER;
                    end
                    OP_I: begin
                        w_ctrl.illegal = w_bad_funct;
                        w_next_state   = w_bad_funct ? S_FETCH : S_EXECUTEI;
                    end
                    OP_BEQ: begin
                        w_ctrl.illegal = (funct3 != 3'b000);
                        w_next_state   = (funct3 == 3'b000) ? S_BEQ : S_FETCH;
                    end
                    OP_JAL:  w_next_state = S_JAL;
                    default: begin
                        w_ctrl.illegal = 1'b1;
                        w_next_state   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_next_state     = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_ctrl.adr_src    = 1'b1;
                w_ctrl.result_src = RESULT_ALUOUT;
                if (mem_ready) begin
                    w_next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_ctrl.result_src = RESULT_READDATA;
                w_ctrl.reg_write  = 1'b1;
                w_next_state      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_ctrl.adr_src    = 1'b1;
                w_ctrl.result_src = RESULT_ALUOUT;
                w_ctrl.mem_write  = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_FETCH;
                end
            end
            S_EXECUTER: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_RS2;
                w_ctrl.alu_op    = ALUOP_FUNCT;
                w_next_state     = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_FUNCT;
                w_next_state     = S_ALUWB;
            end
            S_ALUWB: begin
                w_ctrl.result_src = RESULT_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
                w_next_state      = S_FETCH;
            end
            S_BEQ: begin
                w_ctrl.alu_src_a  = SRCA_RS1;
                w_ctrl.alu_src_b  = SRCB_RS2;
                w_ctrl.alu_op     = ALUOP_SUB;
                w_ctrl.result_src = RESULT_ALUOUT;
                w_ctrl.branch     = 1'b1;
                w_next_state      = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms oldPC+4
                w_ctrl.alu_src_a  = SRCA_OLDPC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RESULT_ALUOUT;
                w_ctrl.pc_update  = 1'b1;
                w_next_state      = S_ALUWB;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    assign w_in_reset    = (r_state == S_RESET);
    assign pc_write      = w_ctrl.pc_update | (w_ctrl.branch & zero);
    assign adr_src       = w_ctrl.adr_src;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign reg_write     = w_ctrl.reg_write;
    assign result_src    = w_ctrl.result_src;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_ctrl      = w_in_reset ? ALU_W'(0) : w_alu_ctrl;
    assign imm_src       = w_in_reset ? IMM_I : imm_src_of(op);
    assign illegal_instr = w_ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed table, stall/reset sequences, random stream.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_ctrl;

    int checks   = 0;
    int failures = 0;

    multicycle_control_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .adr_src      (adr_src),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .reg_write    (reg_write),
        .result_src   (result_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_ctrl     (alu_ctrl),
        .imm_src      (imm_src),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    // Observed (or expected) summary of one instruction
    typedef struct {
        int         t;
        int         n_fetch;
        int         n_irw;
        int         n_pcw;
        int         n_regw;
        int         regw_idx;
        logic [1:0] regw_res;
        int         n_memw;
        int         n_adr1;
        int         n_ill;
        logic [2:0] alu_rs1;
        logic [1:0] b_rs1;
        logic [1:0] imm_dec;
    } res_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         fw;
        int         mw;
        res_t       exp;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic logic [16:0] all_out();
        return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal_instr};
    endfunction

    function automatic int fetch_sig();
        return (alu_src_a == 2'b00 && alu_src_b == 2'b10 && result_src == 2'b10 && adr_src == 1'b0) ? 1 : 0;
    endfunction

    // Reference: instruction-level expectations from opcode class, latencies and stall counts
    function automatic res_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                   input logic z, input int fw, input int mw);
        res_t       r;
        int         kind;
        int         lat[7] = '{5, 4, 4, 4, 3, 4, 2};
        bit         f3ok;
        bit         regw;
        logic [2:0] fn;
        f3ok = (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7);
        case (f3)
            3'd0:    fn = (o == 7'b0110011 && f7) ? 3'b110 : 3'b010;
            3'd2:    fn = 3'b111;
            3'd6:    fn = 3'b001;
            default: fn = 3'b000;
        endcase
        if (o == 7'b0000011)      kind = 0;
        else if (o == 7'b0100011) kind = 1;
        else if (o == 7'b0110011) kind = f3ok ? 2 : 6;
        else if (o == 7'b0010011) kind = f3ok ? 3 : 6;
        else if (o == 7'b1100011) kind = (f3 == 3'd0) ? 4 : 6;
        else if (o == 7'b1101111) kind = 5;
        else                      kind = 6;
        regw       = (kind == 0 || kind == 2 || kind == 3 || kind == 5);
        r.t        = fw + lat[kind] + ((kind <= 1) ? mw : 0);
        r.n_fetch  = fw + 1;
        r.n_irw    = 1;
        r.n_pcw    = 1 + ((kind == 5) ? 1 : 0) + ((kind == 4 && z) ? 1 : 0);
        r.n_regw   = regw ? 1 : 0;
        r.regw_idx = regw ? r.t - 1 : -1;
        r.regw_res = !regw ? 2'b11 : (kind == 0) ? 2'b01 : 2'b00;
        r.n_memw   = (kind == 1) ? mw + 1 : 0;
        r.n_adr1   = (kind <= 1) ? mw + 1 : 0;
        r.n_ill    = (kind == 6) ? 1 : 0;
        if (kind <= 1)                   r.alu_rs1 = 3'b010;
        else if (kind == 2 || kind == 3) r.alu_rs1 = fn;
        else if (kind == 4)              r.alu_rs1 = 3'b110;
        else                             r.alu_rs1 = 3'b100;
        if (kind == 0 || kind == 1 || kind == 3) r.b_rs1 = 2'b01;
        else if (kind == 2 || kind == 4)         r.b_rs1 = 2'b00;
        else                                     r.b_rs1 = 2'b11;
        if (o == 7'b0100011)      r.imm_dec = 2'b01;
        else if (o == 7'b1100011) r.imm_dec = 2'b10;
        else if (o == 7'b1101111) r.imm_dec = 2'b11;
        else                      r.imm_dec = 2'b00;
        return r;
    endfunction

    // Runs exactly t cycles from an instruction's first FETCH cycle (called in the low clock phase)
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int fw, input int mw,
                             input int t, output res_t r);
        bit is_mem;
        is_mem = (o == 7'b0000011 || o == 7'b0100011);
        r = '{t, 0, 0, 0, 0, -1, 2'b11, 0, 0, 0, 3'b100, 2'b11, 2'b00};
        for (int k = 0; k < t; k++) begin
            op = o; funct3 = f3; funct7b5 = f7; zero = z;
            if (k < fw)                                         mem_ready = 1'b0;
            else if (k == fw)                                   mem_ready = 1'b1;
            else if (is_mem && k >= fw + 3 && k < fw + 3 + mw)  mem_ready = 1'b0;
            else if (is_mem && k == fw + 3 + mw)                mem_ready = 1'b1;
            else                                                mem_ready = 1'($urandom_range(0, 1));
            #1;
            r.n_fetch += fetch_sig();
            if (ir_write)  r.n_irw++;
            if (pc_write)  r.n_pcw++;
            if (reg_write) begin
                r.n_regw++;
                r.regw_idx = k;
                r.regw_res = result_src;
            end
            if (mem_write)     r.n_memw++;
            if (adr_src)       r.n_adr1++;
            if (illegal_instr) r.n_ill++;
            if (alu_src_a == 2'b10) begin
                r.alu_rs1 = alu_ctrl;
                r.b_rs1   = alu_src_b;
            end
            if (k == fw + 1) r.imm_dec = imm_src;
            @(negedge clk);
        end
        #1;
        chk({name, ".next_fetch"}, fetch_sig(), 1);
    endtask

    task automatic compare(input string n, input res_t g, input res_t e);
        chk({n, ".n_fetch"},  g.n_fetch,         e.n_fetch);
        chk({n, ".ir_write"}, g.n_irw,           e.n_irw);
        chk({n, ".pc_write"}, g.n_pcw,           e.n_pcw);
        chk({n, ".n_regw"},   g.n_regw,          e.n_regw);
        chk({n, ".regw_idx"}, g.regw_idx,        e.regw_idx);
        chk({n, ".regw_res"}, int'(g.regw_res),  int'(e.regw_res));
        chk({n, ".n_memw"},   g.n_memw,          e.n_memw);
        chk({n, ".n_adr1"},   g.n_adr1,          e.n_adr1);
        chk({n, ".n_ill"},    g.n_ill,           e.n_ill);
        chk({n, ".alu_rs1"},  int'(g.alu_rs1),   int'(e.alu_rs1));
        chk({n, ".b_rs1"},    int'(g.b_rs1),     int'(e.b_rs1));
        chk({n, ".imm_dec"},  int'(g.imm_dec),   int'(e.imm_dec));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs[16];
        res_t       got;
        res_t       exp;
        logic [6:0] ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

        //             op           f3      f7    z    fw mw  t fe irw pcw rw idx  res   mw adr ill alu     b      imm
        vecs[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, '{5, 1, 1, 1, 1, 4, 2'b01, 0, 1, 0, 3'b010, 2'b01, 2'b00}};
        vecs[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, '{4, 1, 1, 1, 0, -1, 2'b11, 1, 1, 0, 3'b010, 2'b01, 2'b01}};
        vecs[2]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, '{4, 1, 1, 1, 1, 3, 2'b00, 0, 0, 0, 3'b110, 2'b00, 2'b00}};
        vecs[3]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, '{4, 1, 1, 1, 1, 3, 2'b00, 0, 0, 0, 3'b010, 2'b00, 2'b00}};
        vecs[4]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0, '{4, 1, 1, 1, 1, 3, 2'b00, 0, 0, 0, 3'b111, 2'b00, 2'b00}};
        vecs[5]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0, '{4, 1, 1, 1, 1, 3, 2'b00, 0, 0, 0, 3'b001, 2'b00, 2'b00}};
        vecs[6]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, '{4, 1, 1, 1, 1, 3, 2'b00, 0, 0, 0, 3'b000, 2'b00, 2'b00}};
        vecs[7]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, '{4, 1, 1, 1, 1, 3, 2'b00, 0, 0, 0, 3'b010, 2'b01, 2'b00}};
        vecs[8]  = '{7'b0010011, 3'b010, 1'b0, 1'b0, 0, 0, '{4, 1, 1, 1, 1, 3, 2'b00, 0, 0, 0, 3'b111, 2'b01, 2'b00}};
        vecs[9]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, '{3, 1, 1, 2, 0, -1, 2'b11, 0, 0, 0, 3'b110, 2'b00, 2'b10}};
        vecs[10] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, '{3, 1, 1, 1, 0, -1, 2'b11, 0, 0, 0, 3'b110, 2'b00, 2'b10}};
        vecs[11] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, '{4, 1, 1, 2, 1, 3, 2'b00, 0, 0, 0, 3'b100, 2'b11, 2'b11}};
        vecs[12] = '{7'b0110011, 3'b100, 1'b0, 1'b0, 0, 0, '{2, 1, 1, 1, 0, -1, 2'b11, 0, 0, 1, 3'b100, 2'b11, 2'b00}};
        vecs[13] = '{7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, '{2, 1, 1, 1, 0, -1, 2'b11, 0, 0, 1, 3'b100, 2'b11, 2'b00}};
        vecs[14] = '{7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, '{2, 1, 1, 1, 0, -1, 2'b11, 0, 0, 1, 3'b100, 2'b11, 2'b10}};
        vecs[15] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 2, 2, '{8, 3, 1, 1, 0, -1, 2'b11, 3, 3, 0, 3'b010, 2'b01, 2'b01}};

        // Power-on reset: everything low, including the opcode-driven imm_src
        rst_n = 1'b0; op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        #2;
        chk("por.outputs", int'(all_out()), 0);
        @(negedge clk); #1;
        chk("por.held", int'(all_out()), 0);
        rst_n = 1'b1; #1;
        chk("por.release", int'(all_out()), 0);
        @(posedge clk); #1;
        chk("por.fetch", fetch_sig(), 1);
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z,
                      vecs[i].fw, vecs[i].mw, vecs[i].exp.t, got);
            compare($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // lw with mem_ready low for 3 cycles in MEMREAD: MEMREAD spans 4 cycles
        run_instr("lw_stall", 7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3, 8, got);
        compare("lw_stall", got, '{8, 1, 1, 1, 1, 7, 2'b01, 0, 4, 0, 3'b010, 2'b01, 2'b00});

        // Reset asserted while stalled in MEMWRITE
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0; #1;
        chk("rst_mid.mem_write_before", int'(mem_write), 1);
        #1 rst_n = 1'b0; #1;
        chk("rst_mid.mem_write_async", int'(mem_write), 0);
        chk("rst_mid.outputs_async", int'(all_out()), 0);
        @(negedge clk); #1;
        chk("rst_mid.held", int'(all_out()), 0);
        rst_n = 1'b1; #1;
        chk("rst_mid.release", int'(all_out()), 0);
        @(posedge clk); #1;
        chk("rst_mid.fetch", fetch_sig(), 1);
        @(negedge clk);

        // Random instruction stream against the instruction-level model
        for (int i = 0; i < 40; i++) begin
            logic [6:0] o;
            logic [2:0] f3;
            logic       f7, z;
            int         sel, fw, mw;
            sel = int'($urandom_range(0, 6));
            o   = (sel == 6) ? 7'($urandom) : ops[sel];
            f3  = 3'($urandom);
            f7  = 1'($urandom);
            z   = 1'($urandom);
            fw  = int'($urandom_range(0, 2));
            mw  = int'($urandom_range(0, 3));
            exp = model(o, f3, f7, z, fw, mw);
            run_instr($sformatf("rnd%0d", i), o, f3, f7, z, fw, mw, exp.t, got);
            compare($sformatf("rnd%0d_op%07b_f%03b", i, o, f3), got, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
